sequential_multiplier: RTL and testbench

SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

---
 rtl/sequential_multiplier_pkg.sv | 47 ++++
 rtl/sequential_multiplier_if.sv | 23 ++
 rtl/sequential_multiplier_datapath.sv | 40 ++++
 rtl/sequential_multiplier.sv | 119 +++++++++++
 tb/tb_sequential_multiplier.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sequential_multiplier_pkg.sv
// Shared constants, FSM encoding and operand helpers for the sequential multiplier.
package sequential_multiplier_pkg;

    // Instruction decode constants for the RV32M multiply group
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL        = 3'b000;
    localparam logic [2:0] F3_MULH       = 3'b001;
    localparam logic [2:0] F3_MULHSU     = 3'b010;
    localparam logic [2:0] F3_MULHU      = 3'b011;

    // One shift-add step per multiplier bit
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Sign/magnitude form of an operand after 33-bit extension
    typedef struct packed {
        logic        neg;
        logic [31:0] mag;
    } operand_t;

    // Magnitude of the 33-bit extended value always fits in 32 bits (largest is 2^31 or 2^32-1)
    function automatic operand_t prep_operand(input logic [31:0] value, input logic is_signed);
        operand_t op;
        op.neg = is_signed & value[31];
        op.mag = op.neg ? (~value + 32'd1) : value;
        return op;
    endfunction

    // Mask clearing the low min(level,32) bits of the multiplier
    function automatic logic [31:0] approx_mask(input logic [7:0] level);
        logic [31:0] m;
        if (level >= 8'd32) begin
            m = '0;
        end else begin
            m = 32'hFFFF_FFFF << level[4:0];
        end
        return m;
    endfunction

endpackage

// File: rtl/sequential_multiplier_if.sv
// Request/response bundle between an issuing core and the sequential multiplier.
interface sequential_multiplier_if;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [7:0]  accuracy_level;
    logic [31:0] bus_rs1;
    logic [31:0] bus_rs2;
    logic        start;
    logic        mul_unit_busy;
    logic        mul_unit_done;
    logic [31:0] mul_output;

    modport master (
        output opcode, funct7, funct3, accuracy_level, bus_rs1, bus_rs2, start,
        input  mul_unit_busy, mul_unit_done, mul_output
    );

    modport slave (
        input  opcode, funct7, funct3, accuracy_level, bus_rs1, bus_rs2, start,
        output mul_unit_busy, mul_unit_done, mul_output
    );
endinterface

// File: rtl/sequential_multiplier_datapath.sv
// Radix-2 shift-add engine: upper half accumulates, lower half holds the unconsumed multiplier bits.
module mul_shift_add_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] mcand_in,
    input  logic [31:0] mplier_in,
    output logic [63:0] product_next
);
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [32:0] sum;

    // Next accumulator: load operands, or add the multiplicand when the current LSB is set and shift right
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        if (load) begin
            mcand_d = mcand_in;
            acc_d   = {32'd0, mplier_in};
        end else if (step) begin
            acc_d = {sum, acc_q[31:1]};
        end
    end

    assign product_next = acc_d;

    // Accumulator and multiplicand registers, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end
endmodule

// File: rtl/sequential_multiplier.sv
// RV32M multiplier: decode, operand sign handling, control FSM and result fix-up around the shift-add engine.
module sequential_multiplier
    import sequential_multiplier_pkg::*;
#(
    parameter int APPROXIMATE = 0,
    parameter int ACCURACY    = 0
) (
    input logic                      clk,
    input logic                      reset,
    sequential_multiplier_if.slave   bus
);
    mul_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        neg_q, neg_d;

    logic        op_valid;
    logic        rs1_signed, rs2_signed;
    logic [31:0] rs2_eff;
    operand_t    op1, op2;
    logic        load, step;
    logic [63:0] product_next;
    logic [63:0] fixed_product;

    // Decode the request and prepare sign/magnitude operands straight from the bus
    always_comb begin
        op_valid   = (bus.opcode == OPCODE_OP) && (bus.funct7 == FUNCT7_MULDIV) &&
                     (bus.funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU});
        rs1_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU);
        rs2_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH);
        rs2_eff    = bus.bus_rs2;
        if (APPROXIMATE != 0 && ACCURACY != 0) begin
            rs2_eff = bus.bus_rs2 & approx_mask(bus.accuracy_level);
        end
        op1 = prep_operand(bus.bus_rs1, rs1_signed);
        op2 = prep_operand(rs2_eff, rs2_signed);
    end

    // Control FSM next-state; busy/done/result are computed here so the outputs come straight from flops
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        neg_d         = neg_q;
        result_d      = result_q;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        load          = 1'b0;
        step          = 1'b0;
        fixed_product = neg_q ? (~product_next + 64'd1) : product_next;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && op_valid) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    funct3_d = bus.funct3;
                    neg_d    = op1.neg ^ op2.neg;
                    load     = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = (funct3_q == F3_MUL) ? fixed_product[31:0] : fixed_product[63:32];
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
        end
    end

    mul_shift_add_datapath u_datapath (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .step         (step),
        .mcand_in     (op1.mag),
        .mplier_in    (op2.mag),
        .product_next (product_next)
    );

    assign bus.mul_unit_busy = busy_q;
    assign bus.mul_unit_done = done_q;
    assign bus.mul_output    = result_q;
endmodule

// File: tb/tb_sequential_multiplier.sv
// Bench for sequential_multiplier: exact, approximate-honoured and approximate-ignored builds driven in lockstep.
module tb_sequential_multiplier;
    import sequential_multiplier_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] last_exact, last_acc, last_noacc;

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    sequential_multiplier_if bus_exact();
    sequential_multiplier_if bus_acc();
    sequential_multiplier_if bus_noacc();

    sequential_multiplier #(.APPROXIMATE(0), .ACCURACY(0)) dut_exact (.clk(clk), .reset(reset), .bus(bus_exact));
    sequential_multiplier #(.APPROXIMATE(1), .ACCURACY(1)) dut_acc   (.clk(clk), .reset(reset), .bus(bus_acc));
    sequential_multiplier #(.APPROXIMATE(1), .ACCURACY(0)) dut_noacc (.clk(clk), .reset(reset), .bus(bus_noacc));

    // Reference RV32M result from wide signed arithmetic
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] lvl, input bit approx);
        logic [31:0] bb;
        logic signed [65:0] ea, eb, prod;
        bit sa, sb;
        bb = b;
        if (approx) begin
            for (int i = 0; i < 32; i++) begin
                if (i < int'(lvl)) bb[i] = 1'b0;
            end
        end
        sa = (f3 != 3'b011);
        sb = (f3 == 3'b000) || (f3 == 3'b001);
        ea = sa ? $signed({{34{a[31]}}, a}) : $signed({34'd0, a});
        eb = sb ? $signed({{34{bb[31]}}, bb}) : $signed({34'd0, bb});
        prod = ea * eb;
        return (f3 == 3'b000) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive_bus(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [7:0] lvl, input logic st);
        bus_exact.opcode = op;  bus_exact.funct7 = f7;  bus_exact.funct3 = f3;
        bus_exact.bus_rs1 = a;  bus_exact.bus_rs2 = b;  bus_exact.accuracy_level = lvl;  bus_exact.start = st;
        bus_acc.opcode = op;    bus_acc.funct7 = f7;    bus_acc.funct3 = f3;
        bus_acc.bus_rs1 = a;    bus_acc.bus_rs2 = b;    bus_acc.accuracy_level = lvl;    bus_acc.start = st;
        bus_noacc.opcode = op;  bus_noacc.funct7 = f7;  bus_noacc.funct3 = f3;
        bus_noacc.bus_rs1 = a;  bus_noacc.bus_rs2 = b;  bus_noacc.accuracy_level = lvl;  bus_noacc.start = st;
    endtask

    task automatic set_start(input logic st);
        bus_exact.start = st;
        bus_acc.start   = st;
        bus_noacc.start = st;
    endtask

    // One full operation; optionally re-pulses start with other operands at a given cycle after acceptance
    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [7:0] lvl, input int inject_at);
        logic [31:0] exp_exact, exp_acc;
        int latency, pulses, busy_cycles;
        exp_exact = ref_mul(f3, a, b, lvl, 1'b0);
        exp_acc   = ref_mul(f3, a, b, lvl, 1'b1);
        latency = 0; pulses = 0; busy_cycles = 0;
        @(negedge clk);
        drive_bus(OPCODE_OP, FUNCT7_MULDIV, f3, a, b, lvl, 1'b1);
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                drive_bus(OPCODE_OP, FUNCT7_MULDIV, 3'($urandom_range(0, 3)), $urandom, $urandom,
                          8'($urandom_range(0, 40)), 1'b0);
            end
            if (inject_at != 0 && c == inject_at) set_start(1'b1);
            if (inject_at != 0 && c == inject_at + 1) set_start(1'b0);
            if (bus_exact.mul_unit_busy === 1'b1) busy_cycles++;
            if (bus_exact.mul_unit_done === 1'b1) begin
                pulses++;
                if (latency == 0) latency = c;
            end
        end
        checkOutput($sformatf("%s.latency", tag), 32'(latency), 32'd33);
        checkOutput($sformatf("%s.done_pulses", tag), 32'(pulses), 32'd1);
        checkOutput($sformatf("%s.busy_cycles", tag), 32'(busy_cycles), 32'd32);
        checkOutput($sformatf("%s.exact", tag), bus_exact.mul_output, exp_exact);
        checkOutput($sformatf("%s.approx_acc", tag), bus_acc.mul_output, exp_acc);
        checkOutput($sformatf("%s.approx_noacc", tag), bus_noacc.mul_output, exp_exact);
        last_exact = exp_exact;
        last_acc   = exp_acc;
        last_noacc = exp_exact;
    endtask

    // A start whose decode does not select a multiply must leave everything untouched
    task automatic run_ignored(input string tag, input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
        int activity;
        activity = 0;
        @(negedge clk);
        drive_bus(op, f7, f3, $urandom, $urandom, 8'd0, 1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus_exact.mul_unit_busy !== 1'b0 || bus_exact.mul_unit_done !== 1'b0) activity++;
        end
        checkOutput($sformatf("%s.activity", tag), 32'(activity), 32'd0);
        checkOutput($sformatf("%s.output_held", tag), bus_exact.mul_output, last_exact);
    endtask

    // Directed scenarios followed by randomized operations
    initial begin
        int after_reset_activity;
        logic [31:0] edge_vals [5];
        logic [31:0] a, b;
        edge_vals = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};

        reset = 1'b0;
        drive_bus(7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 8'd0, 1'b0);
        #12;
        checkOutput("reset.busy", 32'(bus_exact.mul_unit_busy), 32'd0);
        checkOutput("reset.done", 32'(bus_exact.mul_unit_done), 32'd0);
        checkOutput("reset.output", bus_exact.mul_output, 32'd0);
        checkOutput("reset.output_acc", bus_acc.mul_output, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        last_exact = '0;

        applyStimulus("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 8'd0, 0);
        checkOutput("mul_7_m3.const", bus_exact.mul_output, 32'hFFFF_FFEB);
        applyStimulus("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 8'd0, 0);
        checkOutput("mulh_min.const", bus_exact.mul_output, 32'h4000_0000);
        applyStimulus("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 0);
        checkOutput("mulhu_ones.const", bus_exact.mul_output, 32'hFFFF_FFFE);
        applyStimulus("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 0);
        checkOutput("mulhsu_ones.const", bus_exact.mul_output, 32'hFFFF_FFFF);
        applyStimulus("mul_ones", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 0);
        checkOutput("mul_ones.const", bus_exact.mul_output, 32'h0000_0001);
        applyStimulus("approx_lvl4", 3'b000, 32'd3, 32'h13, 8'd4, 0);
        checkOutput("approx_lvl4.acc_const", bus_acc.mul_output, 32'h0000_0030);
        checkOutput("approx_lvl4.noacc_const", bus_noacc.mul_output, 32'h0000_0039);
        applyStimulus("approx_lvl40", 3'b011, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 8'd40, 0);
        applyStimulus("mid_run_start", 3'b000, 32'd1234, 32'd5678, 8'd0, 10);
        checkOutput("mid_run_start.const", bus_exact.mul_output, 32'd7006652);

        run_ignored("bad_funct3", OPCODE_OP, FUNCT7_MULDIV, 3'b100);
        run_ignored("bad_opcode", 7'b0010011, FUNCT7_MULDIV, 3'b000);
        run_ignored("bad_funct7", OPCODE_OP, 7'b0000000, 3'b001);

        // Abort an operation part-way through RUN
        @(negedge clk);
        drive_bus(OPCODE_OP, FUNCT7_MULDIV, 3'b000, 32'h0001_2345, 32'h777, 8'd0, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) set_start(1'b0);
        end
        reset = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(bus_exact.mul_unit_busy), 32'd0);
        checkOutput("abort.done", 32'(bus_exact.mul_unit_done), 32'd0);
        checkOutput("abort.output", bus_exact.mul_output, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        after_reset_activity = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus_exact.mul_unit_done !== 1'b0 || bus_exact.mul_unit_busy !== 1'b0) after_reset_activity++;
        end
        checkOutput("abort.no_done_after_release", 32'(after_reset_activity), 32'd0);
        last_exact = '0;

        applyStimulus("post_reset", 3'b001, 32'hFFFF_FFF0, 32'd100, 8'd0, 0);

        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            applyStimulus($sformatf("rand%0d", i), 3'($urandom_range(0, 3)), a, b, 8'($urandom_range(0, 40)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
